// File: rtl/core_commit_checker.sv
// In-order commit scoreboard: queues DUT and reference register-file writes in two FIFOs,
// compares heads pairwise and reports a Pass/Fail verdict on ebreak or idle timeout.
module core_commit_checker #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              EotReq,
  input  logic              DutWrEn,
  input  logic [ADDR_W-1:0] DutWrAddr,
  input  logic [DATA_W-1:0] DutWrData,
  input  logic [PC_W-1:0]   DutPc,
  input  logic              RefWrEn,
  input  logic [ADDR_W-1:0] RefWrAddr,
  input  logic [DATA_W-1:0] RefWrData,
  input  logic [PC_W-1:0]   RefPc,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [31:0]       MatchCnt,
  output logic [15:0]       MismatchCnt,
  output logic              MismatchValid,
  output logic [PC_W-1:0]   MismatchPc,
  output logic              Overflow,
  output logic              Timeout,
  output logic              Leftover
);

  localparam int unsigned IDX_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PTR_W   = IDX_W + 1;
  localparam int unsigned IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned NSIDE   = 2;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W + PC_W;
  localparam logic [ENTRY_W-1:0] CMP_MASK = {{(ADDR_W + DATA_W){1'b1}}, {PC_W{1'b0}}};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } entryT;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} stateT;

  stateT             state, stateNext;
  entryT             pushEntry [NSIDE];
  entryT             head [NSIDE];
  logic [NSIDE-1:0]  pushReq, pushOk, empty, full;
  logic              active, startRun, pop, headsEqual, anyPush;
  logic              idleHit, drainDone, timeoutSet, overflowSet;
  logic [IDLE_W-1:0] idleCnt;

  // Side 0 is the DUT, side 1 the reference model; x0 writes never enter a FIFO.
  assign active       = (state == StRun) || (state == StDrain);
  assign startRun     = Start && ((state == StIdle) || (state == StDone));
  assign pushEntry[0] = {DutWrAddr, DutWrData, DutPc};
  assign pushEntry[1] = {RefWrAddr, RefWrData, RefPc};
  assign pushReq      = {active & RefWrEn & (RefWrAddr != '0),
                         active & DutWrEn & (DutWrAddr != '0)};

  for (genvar s = 0; s < NSIDE; s++) begin : gFifo
    entryT            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;

    assign empty[s]  = (wrPtr == rdPtr);
    assign full[s]   = (wrPtr[IDX_W] != rdPtr[IDX_W]) &&
                       (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]);
    assign pushOk[s] = pushReq[s] & (~full[s] | pop);
    assign head[s]   = mem[rdPtr[IDX_W-1:0]];

    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else if (startRun) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (pushOk[s]) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)       rdPtr <= rdPtr + PTR_W'(1);
      end
    end

    always_ff @(posedge Clk) begin
      if (pushOk[s]) mem[wrPtr[IDX_W-1:0]] <= pushEntry[s];
    end
  end

  // The pc travels with each entry for reporting only; it never affects equality.
  assign pop         = active & ~empty[0] & ~empty[1];
  assign headsEqual  = ((head[0] ^ head[1]) & CMP_MASK) == '0;
  assign anyPush     = |pushOk;
  assign overflowSet = |(pushReq & full & ~{NSIDE{pop}});
  assign idleHit     = active & ~anyPush & (idleCnt == IDLE_W'(IDLE_TIMEOUT - 1));
  assign drainDone   = (state == StDrain) & (&empty) & ~anyPush;
  assign timeoutSet  = idleHit & ~drainDone;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= StIdle;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      StIdle:  if (Start) stateNext = StRun;
      StRun: begin
        if (idleHit)     stateNext = StDone;
        else if (EotReq) stateNext = StDrain;
      end
      StDrain: if (drainDone || idleHit) stateNext = StDone;
      StDone:  if (Start) stateNext = StRun;
      default: stateNext = StIdle;
    endcase
  end

  // Idle counter, result counters and sticky flags.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idleCnt       <= '0;
      MatchCnt      <= '0;
      MismatchCnt   <= '0;
      MismatchValid <= 1'b0;
      MismatchPc    <= '0;
      Overflow      <= 1'b0;
      Timeout       <= 1'b0;
      Leftover      <= 1'b0;
    end else begin
      MismatchValid <= 1'b0;
      if (startRun) begin
        idleCnt     <= '0;
        MatchCnt    <= '0;
        MismatchCnt <= '0;
        MismatchPc  <= '0;
        Overflow    <= 1'b0;
        Timeout     <= 1'b0;
        Leftover    <= 1'b0;
      end else begin
        if (!active || (stateNext == StDone) || anyPush) begin
          idleCnt <= '0;
        end else if (idleCnt != IDLE_W'(IDLE_TIMEOUT)) begin
          idleCnt <= idleCnt + IDLE_W'(1);
        end
        if (pop) begin
          if (headsEqual) begin
            MatchCnt <= MatchCnt + 32'd1;
          end else begin
            if (MismatchCnt != 16'hFFFF) MismatchCnt <= MismatchCnt + 16'd1;
            MismatchValid <= 1'b1;
            MismatchPc    <= head[0].pc;
          end
        end
        if (overflowSet) Overflow <= 1'b1;
        if (timeoutSet) begin
          Timeout <= 1'b1;
          if (!(&empty)) Leftover <= 1'b1;
        end
      end
    end
  end

  assign Busy = active;
  assign Done = (state == StDone);
  assign Pass = Done && (MismatchCnt == 16'd0) && !Overflow && !Timeout && !Leftover;

endmodule

// File: tb/tb_core_commit_checker.sv
// Directed bench for core_commit_checker: matched, skewed, mismatch, overflow,
// timeout, restart and mid-test reset scenarios with hand-computed expectations.
module tb_core_commit_checker;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned PC_W         = 32;
  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned IDLE_TIMEOUT = 50;

  logic              Clk = 1'b0;
  logic              Rst, Start, EotReq;
  logic              DutWrEn, RefWrEn;
  logic [ADDR_W-1:0] DutWrAddr, RefWrAddr;
  logic [DATA_W-1:0] DutWrData, RefWrData;
  logic [PC_W-1:0]   DutPc, RefPc;
  logic              Busy, Done, Pass, MismatchValid, Overflow, Timeout, Leftover;
  logic [31:0]       MatchCnt;
  logic [15:0]       MismatchCnt;
  logic [PC_W-1:0]   MismatchPc;

  int checks = 0;
  int errors = 0;
  int mvPulses = 0;

  core_commit_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W),
    .FIFO_DEPTH(FIFO_DEPTH), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .EotReq(EotReq),
    .DutWrEn(DutWrEn), .DutWrAddr(DutWrAddr), .DutWrData(DutWrData), .DutPc(DutPc),
    .RefWrEn(RefWrEn), .RefWrAddr(RefWrAddr), .RefWrData(RefWrData), .RefPc(RefPc),
    .Busy(Busy), .Done(Done), .Pass(Pass), .MatchCnt(MatchCnt), .MismatchCnt(MismatchCnt),
    .MismatchValid(MismatchValid), .MismatchPc(MismatchPc),
    .Overflow(Overflow), .Timeout(Timeout), .Leftover(Leftover)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Rst && MismatchValid) mvPulses++;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic busIdle();
    DutWrEn = 1'b0; DutWrAddr = '0; DutWrData = '0; DutPc = '0;
    RefWrEn = 1'b0; RefWrAddr = '0; RefWrData = '0; RefPc = '0;
  endtask

  task automatic setDut(input int a, input int d, input int pc);
    DutWrEn = 1'b1; DutWrAddr = ADDR_W'(a); DutWrData = DATA_W'(d); DutPc = PC_W'(pc);
  endtask

  task automatic setRef(input int a, input int d, input int pc);
    RefWrEn = 1'b1; RefWrAddr = ADDR_W'(a); RefWrData = DATA_W'(d); RefPc = PC_W'(pc);
  endtask

  task automatic pulseStart();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic pulseEot();
    EotReq = 1'b1;
    step();
    EotReq = 1'b0;
  endtask

  // Bounded wait for Done; returns the number of cycles waited.
  task automatic waitDone(input int maxCyc, output int n);
    n = 0;
    while (Done !== 1'b1 && n < maxCyc) begin
      step();
      n++;
    end
    chkBit("wait_done", Done, 1'b1);
  endtask

  initial begin
    int n;
    int base;
    Rst = 1'b0; Start = 1'b0; EotReq = 1'b0;
    busIdle();
    repeat (2) @(posedge Clk);
    #1;
    chkBit("rst_busy", Busy, 1'b0);
    chkBit("rst_done", Done, 1'b0);
    chkBit("rst_pass", Pass, 1'b0);
    chkVal("rst_match", MatchCnt, 32'd0);
    Rst = 1'b1;
    step();
    chkBit("idle_busy", Busy, 1'b0);

    // Matched stream
    pulseStart();
    chkBit("t1_busy", Busy, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      setDut(i, i * 3, i * 4);
      setRef(i, i * 3, i * 4);
      step();
      if (i == 2) chkVal("t1_first_result", MatchCnt, 32'd1);
    end
    busIdle();
    pulseEot();
    waitDone(3, n);
    chkVal("t1_done_latency", 32'(n), 32'd1);
    chkVal("t1_match", MatchCnt, 32'd20);
    chkVal("t1_mismatch", 32'(MismatchCnt), 32'd0);
    chkBit("t1_pass", Pass, 1'b1);
    chkBit("t1_busy_low", Busy, 1'b0);

    // Skewed arrival with x0 writes on the DUT side
    pulseStart();
    chkVal("t2_restart_match", MatchCnt, 32'd0);
    chkBit("t2_restart_done", Done, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      busIdle();
      if (c <= 7) setRef(c + 1, 32'h100 + c, 32'h400 + c);
      if (c >= 5) setDut(c - 4, 32'h100 + c - 5, 32'h800 + c);
      else if (c == 1 || c == 3) setDut(0, 32'hFFFF, 32'h900 + c);
      step();
    end
    busIdle();
    pulseEot();
    waitDone(3, n);
    chkVal("t2_match", MatchCnt, 32'd8);
    chkBit("t2_overflow", Overflow, 1'b0);
    chkBit("t2_pass", Pass, 1'b1);

    // Single mismatch on commit 4
    pulseStart();
    base = mvPulses;
    for (int i = 1; i <= 6; i++) begin
      busIdle();
      if (i == 4) begin
        setDut(i, 32'hDEAD, 32'h10);
        setRef(i, 32'hBEEF, 32'h10);
      end else begin
        setDut(i, i * 16, 32'h100 + i);
        setRef(i, i * 16, 32'h100 + i);
      end
      step();
      if (i == 5) begin
        chkBit("t3_mv_pulse", MismatchValid, 1'b1);
        chkVal("t3_mpc_early", MismatchPc, 32'h10);
      end
      if (i == 6) chkBit("t3_mv_clear", MismatchValid, 1'b0);
    end
    busIdle();
    pulseEot();
    waitDone(3, n);
    chkVal("t3_mv_count", 32'(mvPulses - base), 32'd1);
    chkVal("t3_mismatch", 32'(MismatchCnt), 32'd1);
    chkVal("t3_match", MatchCnt, 32'd5);
    chkVal("t3_mpc", MismatchPc, 32'h10);
    chkBit("t3_pass", Pass, 1'b0);

    // Overflow: nine DUT commits into an eight-deep FIFO
    pulseStart();
    for (int i = 1; i <= 9; i++) begin
      busIdle();
      setDut(i, 32'h200 + i, 32'h300 + i);
      step();
      if (i == 8) chkBit("t4_no_ovf_at_8", Overflow, 1'b0);
      if (i == 9) chkBit("t4_ovf_at_9", Overflow, 1'b1);
    end
    for (int i = 1; i <= 9; i++) begin
      busIdle();
      setRef(i, 32'h200 + i, 32'h300 + i);
      step();
    end
    busIdle();
    chkVal("t4_match", MatchCnt, 32'd8);
    pulseEot();
    waitDone(60, n);
    chkVal("t4_drain_wait", 32'(n), 32'd49);
    chkBit("t4_overflow", Overflow, 1'b1);
    chkBit("t4_leftover", Leftover, 1'b1);
    chkBit("t4_pass", Pass, 1'b0);

    // Idle timeout with no commits at all
    pulseStart();
    chkBit("t5_ovf_cleared", Overflow, 1'b0);
    repeat (49) step();
    chkBit("t5_not_done_49", Done, 1'b0);
    chkBit("t5_busy_49", Busy, 1'b1);
    step();
    chkBit("t5_done_50", Done, 1'b1);
    chkBit("t5_timeout", Timeout, 1'b1);
    chkBit("t5_leftover", Leftover, 1'b0);
    chkBit("t5_pass", Pass, 1'b0);

    // Drain timeout with one unmatched DUT entry
    pulseStart();
    chkBit("t6_timeout_cleared", Timeout, 1'b0);
    setDut(5, 7, 32'h50);
    step();
    busIdle();
    pulseEot();
    waitDone(60, n);
    chkVal("t6_drain_wait", 32'(n), 32'd49);
    chkBit("t6_timeout", Timeout, 1'b1);
    chkBit("t6_leftover", Leftover, 1'b1);
    chkVal("t6_match", MatchCnt, 32'd0);
    chkBit("t6_pass", Pass, 1'b0);

    // Restart from DONE, then reset mid-run with three queued DUT entries
    pulseStart();
    chkBit("t7_timeout_clr", Timeout, 1'b0);
    chkBit("t7_leftover_clr", Leftover, 1'b0);
    chkBit("t7_busy", Busy, 1'b1);
    setDut(1, 1, 32'h40); setRef(1, 1, 32'h40);
    step();
    setDut(2, 5, 32'h44); setRef(2, 6, 32'h44);
    step();
    busIdle();
    for (int i = 3; i <= 5; i++) begin
      setDut(i, i, 32'h50 + i);
      step();
    end
    busIdle();
    chkVal("t8_pre_match", MatchCnt, 32'd1);
    chkVal("t8_pre_mpc", MismatchPc, 32'h44);
    Rst = 1'b0;
    #2;
    chkBit("t8_rst_busy", Busy, 1'b0);
    chkVal("t8_rst_match", MatchCnt, 32'd0);
    chkVal("t8_rst_mismatch", 32'(MismatchCnt), 32'd0);
    chkVal("t8_rst_mpc", MismatchPc, 32'd0);
    chkBit("t8_rst_pass", Pass, 1'b0);
    step();
    Rst = 1'b1;
    step();
    chkBit("t8_idle_busy", Busy, 1'b0);
    chkBit("t8_idle_done", Done, 1'b0);
    pulseEot();
    chkBit("t8_eot_ignored", Busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
